// File: rtl/pwr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwr_sequencer
// Brief    : Ordered PMIC rail power-up/down with pg timeout, settle delay,
//            SoC reset hold and dropout monitoring.
// Revision : 1.0
// ============================================================================
module pwr_sequencer #(
    parameter int NUM_RAILS  = 4,
    parameter int STEP_DELAY = 16,
    parameter int PG_TIMEOUT = 1024,
    parameter int RST_HOLD   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 shutdown,
    input  logic                 clear_fault,
    input  logic [NUM_RAILS-1:0] rail_pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 sys_rst_n,
    output logic                 power_ok,
    output logic                 fault,
    output logic [((NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1)-1:0] fault_rail,
    output logic [2:0]           state
);

    localparam int c_IW   = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
    localparam int c_MAX0 = (PG_TIMEOUT > STEP_DELAY) ? PG_TIMEOUT : STEP_DELAY;
    localparam int c_MAXC = (c_MAX0 > RST_HOLD) ? c_MAX0 : RST_HOLD;
    localparam int c_CW   = $clog2(c_MAXC + 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_RAMP   = 3'd1,
        S_SETTLE = 3'd2,
        S_HOLD   = 3'd3,
        S_ON     = 3'd4,
        S_DOWN   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t                r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [c_IW-1:0]       r_idx;
    logic [NUM_RAILS-1:0]  r_rail_en;
    logic                  r_sys_rst_n;
    logic                  r_power_ok;
    logic                  r_fault;
    logic [c_IW-1:0]       r_fault_rail;

    state_t                w_state_nxt;
    logic [c_CW-1:0]       w_cnt_nxt;
    logic [c_IW-1:0]       w_idx_nxt;
    logic [NUM_RAILS-1:0]  w_rail_en_nxt;
    logic [c_IW-1:0]       w_fault_rail_nxt;
    logic [NUM_RAILS-1:0]  w_drop;
    logic                  w_drop_any;
    logic [c_IW-1:0]       w_drop_idx;

    // Enabled rails whose pg has fallen; lowest index is reported.
    always_comb begin
        w_drop     = r_rail_en & ~rail_pg;
        w_drop_any = 1'b0;
        w_drop_idx = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (w_drop[i]) begin
                w_drop_any = 1'b1;
                w_drop_idx = c_IW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + c_CW'(1);
        w_idx_nxt        = r_idx;
        w_rail_en_nxt    = r_rail_en;
        w_fault_rail_nxt = r_fault_rail;

        case (r_state)
            S_OFF: begin
                w_cnt_nxt = '0;
                if (start && !shutdown) begin
                    w_state_nxt   = S_RAMP;
                    w_idx_nxt     = '0;
                    w_rail_en_nxt = NUM_RAILS'(1);
                end
            end
            S_RAMP: begin
                // pg arriving on the timeout cycle still counts as good
                if (!rail_pg[r_idx] && (r_cnt == c_CW'(PG_TIMEOUT - 1))) begin
                    w_state_nxt      = S_FAULT;
                    w_fault_rail_nxt = r_idx;
                end else if (shutdown) begin
                    w_state_nxt = S_DOWN;
                end else if (rail_pg[r_idx]) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_drop_any) begin
                    w_state_nxt      = S_FAULT;
                    w_fault_rail_nxt = w_drop_idx;
                end else if (shutdown) begin
                    w_state_nxt = S_DOWN;
                end else if (r_cnt == c_CW'(STEP_DELAY - 1)) begin
                    if (r_idx != c_IW'(NUM_RAILS - 1)) begin
                        w_state_nxt              = S_RAMP;
                        w_idx_nxt                = r_idx + c_IW'(1);
                        w_rail_en_nxt[w_idx_nxt] = 1'b1;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_drop_any) begin
                    w_state_nxt      = S_FAULT;
                    w_fault_rail_nxt = w_drop_idx;
                end else if (shutdown) begin
                    w_state_nxt = S_DOWN;
                end else if (r_cnt == c_CW'(RST_HOLD - 1)) begin
                    w_state_nxt = S_ON;
                end
            end
            S_ON: begin
                w_cnt_nxt = '0;
                if (w_drop_any) begin
                    w_state_nxt      = S_FAULT;
                    w_fault_rail_nxt = w_drop_idx;
                end else if (shutdown) begin
                    w_state_nxt = S_DOWN;
                end
            end
            S_DOWN: begin
                if (r_cnt == c_CW'(STEP_DELAY - 1)) begin
                    if (r_idx == '0) begin
                        w_state_nxt = S_OFF;
                    end else begin
                        w_cnt_nxt                = '0;
                        w_idx_nxt                = r_idx - c_IW'(1);
                        w_rail_en_nxt[w_idx_nxt] = 1'b0;
                    end
                end
            end
            S_FAULT: begin
                w_cnt_nxt = '0;
                if (clear_fault) begin
                    w_state_nxt = S_OFF;
                end
            end
            default: begin
                w_state_nxt   = S_OFF;
                w_cnt_nxt     = '0;
                w_idx_nxt     = '0;
                w_rail_en_nxt = '0;
            end
        endcase

        // Entry actions shared by every path into a state
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
        if ((w_state_nxt == S_DOWN) && (r_state != S_DOWN)) begin
            w_rail_en_nxt[r_idx] = 1'b0;
        end
        if (w_state_nxt == S_FAULT) begin
            w_rail_en_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_OFF;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_rail_en    <= '0;
            r_sys_rst_n  <= 1'b0;
            r_power_ok   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_rail <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_rail_en    <= w_rail_en_nxt;
            r_sys_rst_n  <= (w_state_nxt == S_ON);
            r_power_ok   <= (w_state_nxt == S_ON);
            r_fault      <= (w_state_nxt == S_FAULT);
            r_fault_rail <= w_fault_rail_nxt;
        end
    end

    assign rail_en    = r_rail_en;
    assign sys_rst_n  = r_sys_rst_n;
    assign power_ok   = r_power_ok;
    assign fault      = r_fault;
    assign fault_rail = r_fault_rail;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pwr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwr_sequencer
// Brief    : Directed scoreboard bench for pwr_sequencer with a PMIC pg model.
// Revision : 1.0
// ============================================================================
module tb_pwr_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         shutdown = 1'b0;
    logic         clear_fault = 1'b0;
    logic [N-1:0] rail_pg;
    logic [N-1:0] rail_en;
    logic         sys_rst_n;
    logic         power_ok;
    logic         fault;
    logic [1:0]   fault_rail;
    logic [2:0]   state;

    pwr_sequencer #(
        .NUM_RAILS (N),
        .STEP_DELAY(16),
        .PG_TIMEOUT(1024),
        .RST_HOLD  (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .shutdown   (shutdown),
        .clear_fault(clear_fault),
        .rail_pg    (rail_pg),
        .rail_en    (rail_en),
        .sys_rst_n  (sys_rst_n),
        .power_ok   (power_ok),
        .fault      (fault),
        .fault_rail (fault_rail),
        .state      (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PMIC model: pg follows power_on three cycles later, maskable per rail
    logic [N-1:0] pg_d1 = '0, pg_d2 = '0, pg_d3 = '0;
    logic [N-1:0] pg_mask = '1;
    always @(posedge clk) begin
        pg_d1 <= rail_en;
        pg_d2 <= pg_d1;
        pg_d3 <= pg_d2;
    end
    assign rail_pg = pg_d3 & pg_mask;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } ev_t;

    ev_t        q[$];
    logic [6:0] prev_vec = '0;
    int         n_cmp = 0;
    int         n_fail = 0;

    function automatic logic [6:0] mk(input logic f, input logic ok,
                                      input logic rst, input logic [3:0] en);
        return {f, ok, rst, en};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [6:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles; every change of {fault,power_ok,sys_rst_n,rail_en}
    // must match the next queued event in value and cycle.
    task automatic run_watch(input int n);
        logic [6:0] v;
        ev_t        e;
        repeat (n) begin
            tick();
            v = {fault, power_ok, sys_rst_n, rail_en};
            if (v !== prev_vec) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL sb_extra: observed vec %b at cycle %0d expected no change", v, cyc);
                end else begin
                    e = q.pop_front();
                    chk("sb_vec", {25'b0, v}, {25'b0, e.vec});
                    chk("sb_cyc", cyc, e.cyc);
                end
                prev_vec = v;
            end
        end
    endtask

    task automatic power_up();
        int t0;
        t0 = cyc;
        start = 1'b1;
        push(t0 + 1,   mk(0, 0, 0, 4'b0001));
        push(t0 + 21,  mk(0, 0, 0, 4'b0011));
        push(t0 + 41,  mk(0, 0, 0, 4'b0111));
        push(t0 + 61,  mk(0, 0, 0, 4'b1111));
        push(t0 + 113, mk(0, 1, 1, 4'b1111));
        run_watch(1);
        start = 1'b0;
        run_watch(120);
        chk("pu_sb_empty", q.size(), 0);
        chk("pu_state_on", {29'b0, state}, 4);
    endtask

    task automatic do_clear();
        push(cyc + 1, mk(0, 0, 0, 4'b0000));
        clear_fault = 1'b1;
        run_watch(1);
        clear_fault = 1'b0;
        chk("clr_state", {29'b0, state}, 0);
        chk("clr_fault", {31'b0, fault}, 0);
        run_watch(5);
        chk("clr_sb_empty", q.size(), 0);
    endtask

    initial begin
        int t0;
        int c;

        // Reset values
        repeat (3) tick();
        chk("rst_state", {29'b0, state}, 0);
        chk("rst_rail_en", {28'b0, rail_en}, 0);
        chk("rst_sys_rst_n", {31'b0, sys_rst_n}, 0);
        chk("rst_power_ok", {31'b0, power_ok}, 0);
        chk("rst_fault", {31'b0, fault}, 0);
        chk("rst_fault_rail", {30'b0, fault_rail}, 0);
        reset_n = 1'b1;
        run_watch(2);

        // start with shutdown in OFF is ignored
        start = 1'b1;
        shutdown = 1'b1;
        run_watch(3);
        chk("off_both_state", {29'b0, state}, 0);
        start = 1'b0;
        shutdown = 1'b0;
        run_watch(2);

        // Nominal power-up
        power_up();

        // Dropout of rail 1 in ON
        pg_mask[1] = 1'b0;
        push(cyc + 1, mk(1, 0, 0, 4'b0000));
        run_watch(3);
        chk("drop_state", {29'b0, state}, 6);
        chk("drop_fault_rail", {30'b0, fault_rail}, 1);
        pg_mask = '1;
        do_clear();

        // pg timeout on rail 2
        pg_mask[2] = 1'b0;
        t0 = cyc;
        start = 1'b1;
        push(t0 + 1,    mk(0, 0, 0, 4'b0001));
        push(t0 + 21,   mk(0, 0, 0, 4'b0011));
        push(t0 + 41,   mk(0, 0, 0, 4'b0111));
        push(t0 + 1065, mk(1, 0, 0, 4'b0000));
        run_watch(1);
        start = 1'b0;
        run_watch(1070);
        chk("to_sb_empty", q.size(), 0);
        chk("to_state", {29'b0, state}, 6);
        chk("to_fault_rail", {30'b0, fault_rail}, 2);
        pg_mask = '1;
        do_clear();

        // pg on rail 0 arrives exactly on the timeout cycle: pg wins
        pg_mask[0] = 1'b0;
        t0 = cyc;
        start = 1'b1;
        push(t0 + 1, mk(0, 0, 0, 4'b0001));
        run_watch(1);
        start = 1'b0;
        run_watch(1023);
        pg_mask = '1;
        push(t0 + 1041, mk(0, 0, 0, 4'b0011));
        push(t0 + 1061, mk(0, 0, 0, 4'b0111));
        push(t0 + 1081, mk(0, 0, 0, 4'b1111));
        push(t0 + 1133, mk(0, 1, 1, 4'b1111));
        run_watch(1140);
        chk("pgwin_sb_empty", q.size(), 0);
        chk("pgwin_state_on", {29'b0, state}, 4);

        // Shutdown from ON: reverse order, 16 cycles apart
        c = cyc;
        shutdown = 1'b1;
        push(c + 1,  mk(0, 0, 0, 4'b0111));
        push(c + 17, mk(0, 0, 0, 4'b0011));
        push(c + 33, mk(0, 0, 0, 4'b0001));
        push(c + 49, mk(0, 0, 0, 4'b0000));
        run_watch(64);
        chk("down_state_before_off", {29'b0, state}, 5);
        run_watch(2);
        chk("down_state_off", {29'b0, state}, 0);
        chk("down_sb_empty", q.size(), 0);
        shutdown = 1'b0;
        run_watch(2);

        // Shutdown together with pg loss on rails 2 and 3: fault wins
        power_up();
        shutdown = 1'b1;
        pg_mask = 4'b0011;
        push(cyc + 1, mk(1, 0, 0, 4'b0000));
        run_watch(2);
        shutdown = 1'b0;
        chk("sdrop_state", {29'b0, state}, 6);
        chk("sdrop_fault_rail", {30'b0, fault_rail}, 2);
        pg_mask = '1;
        do_clear();

        // Reset asserted mid-RAMP
        t0 = cyc;
        start = 1'b1;
        push(t0 + 1, mk(0, 0, 0, 4'b0001));
        run_watch(1);
        start = 1'b0;
        run_watch(1);
        chk("midramp_state", {29'b0, state}, 1);
        reset_n = 1'b0;
        push(cyc + 1, mk(0, 0, 0, 4'b0000));
        run_watch(1);
        chk("mr_state", {29'b0, state}, 0);
        chk("mr_rail_en", {28'b0, rail_en}, 0);
        chk("mr_sys_rst_n", {31'b0, sys_rst_n}, 0);
        chk("mr_power_ok", {31'b0, power_ok}, 0);
        chk("mr_fault", {31'b0, fault}, 0);
        chk("mr_fault_rail", {30'b0, fault_rail}, 0);
        reset_n = 1'b1;
        run_watch(3);
        chk("mr_stay_off", {29'b0, state}, 0);
        chk("final_sb_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwr_sequencer.md
Name: pwr_sequencer

Overview:
- Sits directly upstream of the PMIC rail blocks. For each rail it drives that rail's power_on input and consumes that rail's power_good output.
- Brings NUM_RAILS rails up in order, with a per-rail power-good timeout and a settle delay after each rail.
- Holds the SoC reset until every rail is good, monitors the rails for dropout, and powers them down in reverse order.

Parameters:
- NUM_RAILS, 4: number of sequenced rails. Rail 0 comes up first and goes down last.
- STEP_DELAY, 16: cycles to wait after a rail's pg is sampled high before enabling the next rail. Also the per-rail spacing during power-down.
- PG_TIMEOUT, 1024: max cycles from rail_en[i] rising to rail_pg[i] sampled high.
- RST_HOLD, 32: cycles sys_rst_n stays low after the last rail settles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  level power-up request, sampled in OFF.
- shutdown  in  1  level power-down request.
- clear_fault  in  1  single-cycle pulse; leaves FAULT.
- rail_pg  in  NUM_RAILS  power_good from each PMIC rail; synchronous to clk.
- rail_en  out  NUM_RAILS  power_on to each PMIC rail.
- sys_rst_n  out  1  downstream SoC reset, active low.
- power_ok  out  1  high only in ON.
- fault  out  1  high only in FAULT.
- fault_rail  out  max(1,$clog2(NUM_RAILS))  index of the faulting rail.
- state  out  3  encoded FSM state, for debug.

Behaviour:
- Reset (reset_n=0 at posedge clk) forces:
  - state=OFF, rail_en=0, sys_rst_n=0, power_ok=0, fault=0, fault_rail=0.
  - All counters cleared and rail index idx=0.
  - Reset mid-sequence drops every rail_en in the same edge.
- State encoding: OFF=0, RAMP=1, SETTLE=2, HOLD=3, ON=4, DOWN=5, FAULT=6.
- OFF:
  - start=1 && shutdown=0 -> RAMP with idx=0 and rail_en[0] set at that edge.
  - start and shutdown both high -> stay OFF.
- RAMP:
  - Counter runs from 0 while rail_en[idx]=1.
  - rail_pg[idx]=1 -> SETTLE, counter=0.
  - Counter reaches PG_TIMEOUT-1 without pg -> FAULT with fault_rail=idx.
- SETTLE:
  - Counts STEP_DELAY cycles.
  - Then if idx<NUM_RAILS-1: idx++, set rail_en[idx], go to RAMP.
  - Else go to HOLD.
- HOLD:
  - Counts RST_HOLD cycles, then -> ON.
  - On entering ON: sys_rst_n=1 and power_ok=1 at the same edge.
- Dropout rule, applies in SETTLE, HOLD and ON:
  - If any already-enabled rail has rail_pg=0 -> FAULT.
  - fault_rail = lowest such index.
  - Rails not yet enabled are ignored.
- shutdown=1 in RAMP/SETTLE/HOLD/ON -> DOWN.
  - Entering DOWN, sys_rst_n=0 and power_ok=0 at the same edge.
  - idx = highest enabled rail.
- DOWN:
  - Clears rail_en[idx], waits STEP_DELAY cycles, decrements idx.
  - After rail 0 is cleared and its STEP_DELAY elapses -> OFF.
  - pg is not checked in DOWN.
  - start is ignored in DOWN.
- FAULT:
  - At the entry edge: rail_en=0 (all rails at once), sys_rst_n=0, power_ok=0, fault=1.
  - Stays in FAULT until clear_fault=1, then -> OFF with fault=0.
  - start is not acted on in the clear cycle; it is re-sampled in OFF on the next cycle.
- Simultaneous events:
  - pg loss or timeout together with shutdown -> FAULT wins.
  - Timeout and pg arriving in the same cycle -> pg wins (SETTLE).
- Outputs are registered. sys_rst_n is never high unless state=ON.
- Counters are wide enough for max(PG_TIMEOUT, STEP_DELAY, RST_HOLD) and saturate-free; each is cleared on every state entry.

Test Plan:
- Nominal power-up: start=1 at T0; bench echoes each rail_pg 3 cycles after its rail_en rises.
  - rail_en bits rise in order 0..3, each 3+16+1 cycles apart.
  - sys_rst_n and power_ok go high 32 cycles after rail 3's SETTLE ends.
  - state=4.
- Timeout: rail 2 pg held 0.
  - Exactly 1024 cycles after rail_en[2] rises: fault=1, fault_rail=2, rail_en=0, state=6.
  - clear_fault pulse -> state=0, fault=0.
- Dropout in ON: drop rail_pg[1].
  - Next edge: state=6, fault_rail=1, rail_en=0000, sys_rst_n=0, power_ok=0.
- Shutdown from ON:
  - rail_en goes 1111 -> 0111 -> 0011 -> 0001 -> 0000, steps 16 cycles apart.
  - sys_rst_n=0 at DOWN entry; state=0 after the final 16 cycles.
- Edge cases:
  - start and shutdown together in OFF -> stays OFF.
  - shutdown together with pg drop in ON -> FAULT.
  - reset_n=0 mid-RAMP -> every output at its reset value at the next edge.
